// File: rtl/kernel_share_arb_if.sv
// Handshake and kernel-side bundle for kernel_share_arb.
// The master side is the environment (requesting FSMs plus the kernel);
// the slave side is the arbiter itself.
interface kernel_share_arb_if #(
  parameter int NREQ = 4,
  parameter int NARG = 7,
  parameter int W    = 64
);
  // Requester side
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*NARG*W-1:0] req_args;
  logic [NREQ-1:0]        req_ctrl;
  logic [NREQ-1:0]        resp_valid;
  logic [W-1:0]           resp_result;
  logic                   resp_err;

  // Kernel side
  logic                   k_r_enable;
  logic [NARG*W-1:0]      k_args;
  logic                   k_controlArr;
  logic                   k_w_enable;
  logic [W-1:0]           k_result;

  modport master (
    output req_valid, req_args, req_ctrl, k_w_enable, k_result,
    input  req_ready, resp_valid, resp_result, resp_err,
           k_r_enable, k_args, k_controlArr
  );

  modport slave (
    input  req_valid, req_args, req_ctrl, k_w_enable, k_result,
    output req_ready, resp_valid, resp_result, resp_err,
           k_r_enable, k_args, k_controlArr
  );
endinterface

// File: rtl/kernel_share_arb.sv
// Round-robin scheduler sharing one HLS kernel among NREQ requesters.
// One job at a time: accept, launch (start pulse), wait for the done
// rising edge or a timeout, then return the result to the job owner.
module kernel_share_arb #(
  parameter int NREQ    = 4,
  parameter int NARG    = 7,
  parameter int W       = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  kernel_share_arb_if.slave   bus,
  output logic                busy,
  output logic [15:0]         jobs_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = NARG * W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   last_r;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   grant_s;
  logic            found_s;
  logic [TW-1:0]   timer_r;
  logic            kw_d_r;
  logic            done_s;
  logic [NREQ-1:0] ready_s;
  logic [AW-1:0]   sel_args_s;
  logic            sel_ctrl_s;
  logic [AW-1:0]   k_args_r;
  logic            k_ctrl_r;
  logic            k_r_enable_r;
  logic [NREQ-1:0] resp_valid_r;
  logic [W-1:0]    resp_result_r;
  logic            resp_err_r;
  logic            busy_r;
  logic [15:0]     jobs_done_r;

  // One-hot vector with bit idx set
  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid requester after the last one served
  always_comb begin
    grant_s = {IW{1'b0}};
    found_s = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last_r) + off) % NREQ);
      if (!found_s && bus.req_valid[cand]) begin
        found_s = 1'b1;
        grant_s = cand;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Mux the granted requester's arguments and control bit
  always_comb begin
    sel_args_s = {AW{1'b0}};
    sel_ctrl_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == IW'(i)) begin
        sel_args_s = bus.req_args[i*AW +: AW];
        sel_ctrl_s = bus.req_ctrl[i];
      end else begin
        sel_ctrl_s = sel_ctrl_s;
      end
    end
  end

  // Ready is offered only while idle, to the granted requester
  always_comb begin
    if ((state_r == IDLE) && found_s) begin
      ready_s = onehot(grant_s);
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  // Completion is a rising edge of the kernel done level
  assign done_s = bus.k_w_enable & ~kw_d_r;

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      last_r        <= IW'(NREQ - 1);
      owner_r       <= {IW{1'b0}};
      timer_r       <= {TW{1'b0}};
      kw_d_r        <= 1'b0;
      k_args_r      <= {AW{1'b0}};
      k_ctrl_r      <= 1'b0;
      k_r_enable_r  <= 1'b0;
      resp_valid_r  <= {NREQ{1'b0}};
      resp_result_r <= {W{1'b0}};
      resp_err_r    <= 1'b0;
      busy_r        <= 1'b0;
      jobs_done_r   <= 16'd0;
    end else begin
      kw_d_r <= bus.k_w_enable;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            k_args_r     <= sel_args_s;
            k_ctrl_r     <= sel_ctrl_s;
            owner_r      <= grant_s;
            last_r       <= grant_s;
            k_r_enable_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= LAUNCH;
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          k_r_enable_r <= 1'b0;
          timer_r      <= {TW{1'b0}};
          state_r      <= WAIT;
        end
        WAIT: begin
          // A done edge in the timeout cycle still counts as success
          if (done_s) begin
            resp_valid_r  <= onehot(owner_r);
            resp_result_r <= bus.k_result;
            resp_err_r    <= 1'b0;
            state_r       <= RESP;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            resp_valid_r  <= onehot(owner_r);
            resp_result_r <= {W{1'b0}};
            resp_err_r    <= 1'b1;
            state_r       <= RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RESP: begin
          if (!resp_err_r) begin
            jobs_done_r <= jobs_done_r + 16'd1;
          end else begin
            jobs_done_r <= jobs_done_r;
          end
          resp_valid_r  <= {NREQ{1'b0}};
          resp_result_r <= {W{1'b0}};
          resp_err_r    <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          k_r_enable_r <= 1'b0;
          resp_valid_r <= {NREQ{1'b0}};
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_result  = resp_result_r;
  assign bus.resp_err     = resp_err_r;
  assign bus.k_r_enable   = k_r_enable_r;
  assign bus.k_args       = k_args_r;
  assign bus.k_controlArr = k_ctrl_r;
  assign busy             = busy_r;
  assign jobs_done        = jobs_done_r;

endmodule

// File: tb/tb_kernel_share_arb.sv
// Self-checking bench for kernel_share_arb: table of single jobs, a
// round-robin burst, and hand-written stale-done, withdrawal and
// mid-job reset sequences. Responses are checked against a scoreboard.
module tb_kernel_share_arb;
  localparam int NREQ = 4;
  localparam int NARG = 7;
  localparam int W    = 64;
  localparam int TMO  = 16;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [15:0] jobs_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [NREQ-1:0] owner;
    logic [W-1:0]    result;
    logic            err;
  } exp_t;
  exp_t sb[$];

  // kernel model controls: 0 = done pulse after klat, 1 = silent, 2 = manual level
  int          kmode = 0;
  int          klat  = 1;
  int          kcnt  = 0;
  logic        manual_w = 1'b0;
  logic        model_w  = 1'b0;
  logic [W-1:0] model_res = '0;

  int launches      = 0;
  int resp_count    = 0;
  int last_resp_cyc = 0;

  kernel_share_arb_if #(.NREQ(NREQ), .NARG(NARG), .W(W)) bus ();

  kernel_share_arb #(.NREQ(NREQ), .NARG(NARG), .W(W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  assign bus.k_w_enable = (kmode == 2) ? manual_w : model_w;
  assign bus.k_result   = model_res;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] exp_sum(input logic [W-1:0] base, input logic [W-1:0] step,
                                           input logic ctrl);
    return 64'd7 * base + 64'd21 * step + (ctrl ? 64'd1000 : 64'd0);
  endfunction

  task automatic push_exp(input int owner, input logic [W-1:0] result, input logic err);
    exp_t e;
    e.owner = '0;
    e.owner[owner] = 1'b1;
    e.result = result;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic load_job(input int i, input logic [W-1:0] base, input logic [W-1:0] step,
                          input logic ctrl);
    for (int k = 0; k < NARG; k++) bus.req_args[(i*NARG+k)*W +: W] = base + W'(k) * step;
    bus.req_ctrl[i]  = ctrl;
    bus.req_valid[i] = 1'b1;
  endtask

  // Call right after a negedge; returns the requester accepted on the next posedge
  task automatic wait_accept(output int idx, output int c);
    idx = -1;
    c = 0;
    for (int n = 0; n < 300 && idx < 0; n++) begin
      #1;
      if ((bus.req_valid & bus.req_ready) != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_valid[i] & bus.req_ready[i]) idx = i;
        c = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected an accept");
    end
  endtask

  task automatic wait_resp_count(input int target);
    for (int n = 0; n < 300 && resp_count < target; n++) begin
      @(negedge clk);
      #2;
    end
    if (resp_count < target) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", resp_count, target);
    end
  endtask

  // Kernel model: result = sum of args (+1000 if controlArr), done after klat cycles
  initial begin
    forever begin
      @(negedge clk);
      if (bus.k_r_enable) begin
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < NARG; k++) s = s + bus.k_args[k*W +: W];
        model_res = s + (bus.k_controlArr ? 64'd1000 : 64'd0);
        kcnt = (kmode == 0) ? klat : 0;
        model_w = 1'b0;
      end else if (kcnt > 0) begin
        kcnt--;
        model_w = (kcnt == 0);
      end else begin
        model_w = 1'b0;
      end
    end
  end

  // Response monitor and scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.k_r_enable) launches++;
        chk("ready_outside_idle", 64'(busy && (bus.req_ready != '0)), 64'd0);
        if (bus.resp_valid != '0) begin
          resp_count++;
          last_resp_cyc = cyc;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid %b expected none", bus.resp_valid);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_owner", 64'(bus.resp_valid), 64'(e.owner));
            chk("resp_result", bus.resp_result, e.result);
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int           req;
    logic [W-1:0] base;
    logic [W-1:0] step;
    logic         ctrl;
    int           lat;
    int           mode;
    logic [W-1:0] exp_result;
    logic         exp_err;
    logic [15:0]  exp_done;
    int           exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int idx;
    int c;
    int rc;
    int l0;
    int order[5];
    logic [NARG*W-1:0] exp_args;

    tbl[0] = '{req:0, base:64'd123, step:64'd111, ctrl:1'b0, lat:6, mode:0,
               exp_result:64'd3192, exp_err:1'b0, exp_done:16'd6, exp_lat:8};
    tbl[1] = '{req:2, base:64'd1000, step:64'd1, ctrl:1'b1, lat:1, mode:0,
               exp_result:64'd8021, exp_err:1'b0, exp_done:16'd7, exp_lat:3};
    tbl[2] = '{req:3, base:64'hFFFF_FFFF_FFFF_FFF0, step:64'd2, ctrl:1'b0, lat:3, mode:0,
               exp_result:64'hFFFF_FFFF_FFFF_FFBA, exp_err:1'b0, exp_done:16'd8, exp_lat:5};
    tbl[3] = '{req:1, base:64'd5, step:64'd5, ctrl:1'b0, lat:1, mode:1,
               exp_result:64'd0, exp_err:1'b1, exp_done:16'd8, exp_lat:TMO+2};
    tbl[4] = '{req:1, base:64'd10, step:64'd10, ctrl:1'b1, lat:2, mode:0,
               exp_result:64'd1280, exp_err:1'b0, exp_done:16'd9, exp_lat:4};
    order = '{0, 1, 2, 3, 0};

    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_args  = '0;
    bus.req_ctrl  = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_jobs_done", 64'(jobs_done), 64'd0);
    chk("rst_k_r_enable", 64'(bus.k_r_enable), 64'd0);
    chk("rst_k_args_lo", bus.k_args[W-1:0], 64'd0);
    chk("rst_k_ctrl", 64'(bus.k_controlArr), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_result", bus.resp_result, 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Round-robin burst: all four requesters valid, five jobs
    kmode = 0;
    klat  = 2;
    rc = resp_count;
    for (int i = 0; i < NREQ; i++) begin
      load_job(i, 64'(100 * (i + 1)), 64'(i + 1), 1'b0);
      push_exp(i, exp_sum(64'(100 * (i + 1)), 64'(i + 1), 1'b0), 1'b0);
    end
    push_exp(0, exp_sum(64'd5000, 64'd7, 1'b0), 1'b0);
    for (int n = 0; n < 5; n++) begin
      wait_accept(idx, c);
      chk("rr_grant", 64'(idx), 64'(order[n]));
      @(negedge clk);
      if (n == 0) load_job(0, 64'd5000, 64'd7, 1'b0);
      else if (idx >= 0) bus.req_valid[idx] = 1'b0;
      else bus.req_valid = '0;
    end
    wait_resp_count(rc + 5);
    @(negedge clk);
    chk("rr_jobs_done", 64'(jobs_done), 64'd5);

    // Table of single jobs, including a timeout and its recovery
    for (int v = 0; v < 5; v++) begin
      kmode = tbl[v].mode;
      klat  = tbl[v].lat;
      rc = resp_count;
      load_job(tbl[v].req, tbl[v].base, tbl[v].step, tbl[v].ctrl);
      push_exp(tbl[v].req, tbl[v].exp_result, tbl[v].exp_err);
      for (int k = 0; k < NARG; k++) exp_args[k*W +: W] = tbl[v].base + W'(k) * tbl[v].step;
      wait_accept(idx, c);
      chk("tbl_grant", 64'(idx), 64'(tbl[v].req));
      @(negedge clk);
      bus.req_valid = '0;
      chk("tbl_k_r_enable", 64'(bus.k_r_enable), 64'd1);
      for (int k = 0; k < NARG; k++) chk("tbl_k_args", bus.k_args[k*W +: W], exp_args[k*W +: W]);
      chk("tbl_k_ctrl", 64'(bus.k_controlArr), 64'(tbl[v].ctrl));
      wait_resp_count(rc + 1);
      chk("tbl_latency", 64'(last_resp_cyc - c), 64'(tbl[v].exp_lat));
      @(negedge clk);
      chk("tbl_jobs_done", 64'(jobs_done), 64'(tbl[v].exp_done));
      chk("tbl_busy", 64'(busy), 64'd0);
    end

    // Stale done: level already high at launch, only the later edge counts
    kmode = 2;
    manual_w = 1'b1;
    rc = resp_count;
    load_job(3, 64'd1, 64'd1, 1'b0);
    push_exp(3, 64'd28, 1'b0);
    wait_accept(idx, c);
    chk("stale_grant", 64'(idx), 64'd3);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    manual_w = 1'b0;
    repeat (4) @(negedge clk);
    manual_w = 1'b1;
    wait_resp_count(rc + 1);
    chk("stale_latency", 64'(last_resp_cyc - c), 64'd9);
    @(negedge clk);
    manual_w = 1'b0;
    kmode = 0;
    chk("stale_jobs_done", 64'(jobs_done), 64'd10);

    // Withdrawal: requester 2 raises then drops valid while requester 1 runs
    klat = 10;
    rc = resp_count;
    l0 = launches;
    load_job(1, 64'd2, 64'd3, 1'b0);
    push_exp(1, 64'd77, 1'b0);
    wait_accept(idx, c);
    chk("wd_grant", 64'(idx), 64'd1);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    load_job(2, 64'd9, 64'd9, 1'b1);
    repeat (3) @(negedge clk);
    bus.req_valid[2] = 1'b0;
    wait_resp_count(rc + 1);
    chk("wd_latency", 64'(last_resp_cyc - c), 64'd12);
    repeat (15) @(negedge clk);
    chk("wd_launches", 64'(launches), 64'(l0 + 1));
    chk("wd_jobs_done", 64'(jobs_done), 64'd11);

    // Reset in the middle of WAIT: job dropped, no response
    kmode = 1;
    load_job(0, 64'd3, 64'd3, 1'b0);
    wait_accept(idx, c);
    chk("mr_grant", 64'(idx), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_jobs_done", 64'(jobs_done), 64'd0);
    chk("mr_k_args_lo", bus.k_args[W-1:0], 64'd0);
    chk("mr_k_r_enable", 64'(bus.k_r_enable), 64'd0);
    chk("mr_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mr_resp_err", 64'(bus.resp_err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    kmode = 0;
    klat  = 3;
    rc = resp_count;
    load_job(2, 64'd20, 64'd1, 1'b0);
    load_job(0, 64'd30, 64'd2, 1'b0);
    push_exp(0, 64'd252, 1'b0);
    push_exp(2, 64'd161, 1'b0);
    wait_accept(idx, c);
    chk("mr_first_grant", 64'(idx), 64'd0);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    wait_accept(idx, c);
    chk("mr_second_grant", 64'(idx), 64'd2);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    wait_resp_count(rc + 2);
    @(negedge clk);
    chk("mr_jobs_done_after", 64'(jobs_done), 64'd2);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
